// File: rtl/alarm_seq_pkg.sv
// Shared types and widths for the alarm sequencer and its time comparator.
package alarm_seq_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int TIME_W      = 4 * BCD_DIGIT_W;
    localparam int RING_CNT_W  = 8;
    localparam int MIN_CNT_W   = 4;
    localparam int SNZ_CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_time_cmp.sv
// Purely combinational HH:MM equality compare; also shared with the display blink logic.
module alarm_time_cmp
    import alarm_seq_pkg::*;
(
    input  logic [TIME_W-1:0] lhs,
    input  logic [TIME_W-1:0] rhs,
    output logic              match
);

    assign match = (lhs == rhs);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring / snooze / lockout sequencer driving the buzzer.
// Optional macro ALARM_SEQ_BLINK_EN gates sound_alarm with a 1 s on / 1 s off blink.
module alarm_sequencer
    import alarm_seq_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 one_second,
    input  logic                 one_minute,
    input  logic [TIME_W-1:0]    current_time,
    input  logic [TIME_W-1:0]    alarm_time,
    input  logic                 alarm_enable,
    input  logic                 stop_button,
    input  logic                 snooze_button,
    output logic                 sound_alarm,
    output logic                 snooze_active,
    output logic [SNZ_CNT_W-1:0] snooze_count,
    output logic                 ring_timeout
);

    // Counters compare against "last value" so the terminal pulse is the one that expires.
    localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SECS - 1);
    localparam logic [MIN_CNT_W-1:0]  MIN_LAST  = MIN_CNT_W'(SNOOZE_MINS - 1);
    localparam logic [SNZ_CNT_W-1:0]  SNZ_MAX   = SNZ_CNT_W'(MAX_SNOOZE);

    state_t                 state;
    state_t                 state_next;
    logic                   match;
    logic                   ring_expire;
    logic                   snooze_take;
    logic                   ring_entry;
    logic [RING_CNT_W-1:0]  ring_cnt;
    logic [MIN_CNT_W-1:0]   min_cnt;
    logic [SNZ_CNT_W-1:0]   snz_cnt;
    logic                   ring_timeout_q;
`ifdef ALARM_SEQ_BLINK_EN
    logic                   blink;
`endif

    alarm_time_cmp u_cmp (
        .lhs   (current_time),
        .rhs   (alarm_time),
        .match (match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ring_expire = 1'b0;
        snooze_take = 1'b0;
        case (state)
            IDLE: begin
                if (alarm_enable && match) begin
                    state_next = RINGING;
                end
            end
            RINGING: begin
                if (!alarm_enable) begin
                    state_next = IDLE;
                end else if (stop_button) begin
                    state_next = DONE;
                end else if (snooze_button) begin
                    if (snz_cnt < SNZ_MAX) begin
                        state_next  = SNOOZE;
                        snooze_take = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end else if (one_second && (ring_cnt == RING_LAST)) begin
                    state_next  = DONE;
                    ring_expire = 1'b1;
                end
            end
            SNOOZE: begin
                if (!alarm_enable || stop_button) begin
                    state_next = IDLE;
                end else if (one_minute && (min_cnt == MIN_LAST)) begin
                    state_next = RINGING;
                end
            end
            DONE: begin
                if (!match || !alarm_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ring_entry = (state != RINGING) && (state_next == RINGING);

    // ring_timeout is registered so it lines up with the first cycle spent in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            ring_cnt       <= '0;
            min_cnt        <= '0;
            snz_cnt        <= '0;
            ring_timeout_q <= 1'b0;
        end else begin
            ring_timeout_q <= ring_expire;
            if (ring_entry) begin
                ring_cnt <= '0;
            end else if ((state == RINGING) && one_second) begin
                ring_cnt <= ring_cnt + RING_CNT_W'(1);
            end
            if (snooze_take) begin
                min_cnt <= '0;
            end else if ((state == SNOOZE) && one_minute) begin
                min_cnt <= min_cnt + MIN_CNT_W'(1);
            end
            if ((state == IDLE) && (state_next == RINGING)) begin
                snz_cnt <= '0;
            end else if (snooze_take) begin
                snz_cnt <= snz_cnt + SNZ_CNT_W'(1);
            end
        end
    end

`ifdef ALARM_SEQ_BLINK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            blink <= 1'b0;
        end else if (ring_entry) begin
            blink <= 1'b1;
        end else if ((state == RINGING) && one_second) begin
            blink <= ~blink;
        end
    end

    always_comb begin
        sound_alarm   = (state == RINGING) && blink;
        snooze_active = (state == SNOOZE);
    end
`else
    always_comb begin
        sound_alarm   = (state == RINGING);
        snooze_active = (state == SNOOZE);
    end
`endif

    assign snooze_count = snz_cnt;
    assign ring_timeout = ring_timeout_q;

endmodule
